mux16_scan_seq: RTL and testbench

//  Sequencer that drives the 16:1 inverting mux stage (16 data, 4 select, active-high disable).
//  It accepts a command (data word, start index, step count) and holds the word on the mux data inputs.
//  It then steps the select lines, sampling the mux output once per step.
//  It returns the de-inverted samples as one result word over a valid/ready handshake.
//  It sits directly upstream of the mux and also consumes the mux output.

---
 rtl/mux16_pkg.sv | 15 +
 rtl/mux16_step_timer.sv | 27 ++
 rtl/mux16_scan_seq.sv | 129 ++++++++++++
 tb/tb_mux16_scan_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux16_pkg.sv
// Shared types and helpers for the 16:1 mux scan sequencer.
package mux16_pkg;

  localparam int N_IN  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {IDLE, STEP, RESP} state_e;

  // Zero and anything above 16 both mean a full 16-step scan.
  function automatic logic [4:0] eff_count(input logic [4:0] cnt);
    if (cnt == 5'd0 || cnt > 5'd16) return 5'd16;
    return cnt;
  endfunction

endpackage

// File: rtl/mux16_step_timer.sv
// Per-step down-counter: a step is LAT+1 cycles, with sample_o high on its last cycle.
module mux16_step_timer #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic sample_o
);

  localparam logic [2:0] LAT_V = 3'(LAT);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = LAT_V;
    if (run_i && cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= LAT_V;
    else     cnt_q <= cnt_d;
  end

  assign sample_o = run_i && (cnt_q == 3'd0);

endmodule

// File: rtl/mux16_scan_seq.sv
// Drives the inverting 16:1 mux through a select scan and returns the de-inverted samples.
module mux16_scan_seq
  import mux16_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N_IN-1:0]   cmd_word,
  input  logic [SEL_W-1:0]  cmd_start,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic [N_IN-1:0]   mux_data,
  output logic [SEL_W-1:0]  mux_sel,
  output logic              mux_dis,
  input  logic              mux_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_IN-1:0]   res_bits,
  output logic [CNT_W-1:0]  res_len,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] LAT_V = 3'(LAT);

  state_e             state_q, state_d;
  logic [N_IN-1:0]    word_q, word_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [4:0]         len_q, len_d;
  logic [4:0]         k_q, k_d;
  logic [N_IN-1:0]    bits_q, bits_d;
  logic               fin_q, fin_d;
  logic               err_q, err_d;
  logic [2:0]         dis_cnt_q, dis_cnt_d;
  logic               run;
  logic               sample;

  // fin_q marks the settle cycle after the final sample; the mux is already released then.
  assign run = (state_q == STEP) && !fin_q;

  mux16_step_timer #(.LAT(LAT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run_i    (run),
    .sample_o (sample)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    len_d   = len_q;
    k_d     = k_q;
    bits_d  = bits_q;
    fin_d   = fin_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = STEP;
          word_d  = cmd_word;
          sel_d   = cmd_start;
          len_d   = eff_count(5'(cmd_count));
          k_d     = 5'd0;
          bits_d  = '0;
          fin_d   = 1'b0;
        end
      end
      STEP: begin
        if (fin_q) begin
          state_d = RESP;
          fin_d   = 1'b0;
        end else if (sample) begin
          bits_d[k_q[3:0]] = ~mux_o;
          sel_d = sel_q + 1'b1;
          k_d   = k_q + 5'd1;
          if (k_q == len_q - 5'd1) fin_d = 1'b1;
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The idle check only trusts mux_o once the disable has had LAT cycles to propagate.
  always_comb begin
    dis_cnt_d = 3'd0;
    if (mux_dis) dis_cnt_d = (dis_cnt_q < LAT_V) ? dis_cnt_q + 3'd1 : dis_cnt_q;
    err_d = err_q | ((state_q == IDLE) && (dis_cnt_q >= LAT_V) && !mux_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= 5'd0;
      fin_q     <= 1'b0;
      err_q     <= 1'b0;
      dis_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      fin_q     <= fin_d;
      err_q     <= err_d;
      dis_cnt_q <= dis_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
    sel_q  <= sel_d;
    len_q  <= len_d;
    bits_q <= bits_d;
  end

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign mux_dis   = !run;
  assign mux_data  = run ? word_q : '0;
  assign mux_sel   = run ? sel_q : '0;
  assign res_valid = (state_q == RESP);
  assign res_bits  = res_valid ? bits_q : '0;
  assign res_len   = res_valid ? CNT_W'(len_q) : '0;
  assign err       = err_q;

endmodule

// File: tb/tb_mux16_scan_seq.sv
// Bench for mux16_scan_seq with a registered behavioural model of the inverting mux.
module tb_mux16_scan_seq;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_word = '0;
  logic [3:0]  cmd_start = '0;
  logic [4:0]  cmd_count = '0;
  logic [15:0] mux_data;
  logic [3:0]  mux_sel;
  logic        mux_dis;
  logic        mux_o_q = 1'b1;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_bits;
  logic [4:0]  res_len;
  logic        busy;
  logic        err;
  logic        force_lo = 1'b0;

  int checks = 0;
  int errors = 0;
  int sel_log[$];

  mux16_scan_seq #(.LAT(LAT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .cmd_start(cmd_start), .cmd_count(cmd_count),
    .mux_data(mux_data), .mux_sel(mux_sel), .mux_dis(mux_dis), .mux_o(mux_o_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_bits(res_bits),
    .res_len(res_len), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Mux model with one cycle of delay, matching LAT=1.
  always @(posedge clk)
    mux_o_q <= force_lo ? 1'b0 : (mux_dis | ~mux_data[mux_sel]);

  function automatic int eff(input int c);
    return (c == 0 || c > 16) ? 16 : c;
  endfunction

  function automatic logic [15:0] exp_bits(input logic [15:0] w, input int start, input int n);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = w[(start + k) % 16];
    return r;
  endfunction

  task automatic issue(input logic [15:0] w, input logic [3:0] s, input logic [4:0] c);
    int t;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL issue_wait_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_word = w; cmd_start = s; cmd_count = c; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(output int n, output bit to);
    n = 0; to = 1'b0;
    sel_log.delete();
    forever begin
      if (!mux_dis) sel_log.push_back(int'(mux_sel));
      @(posedge clk); #1; n++;
      if (res_valid) break;
      if (n >= 200) begin to = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, mux_dis, res_valid, busy, err} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_ctrl: rdy,dis,rv,busy,err=%b required 01000",
               {cmd_ready, mux_dis, res_valid, busy, err});
    end
    checks++;
    if ({mux_data, mux_sel, res_bits, res_len} !== 41'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h sel=%0d bits=%h len=%0d required 0",
               mux_data, mux_sel, res_bits, res_len);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic;
    int n; bit to;
    res_ready = 1'b1;
    issue(16'hA5A5, 4'd0, 5'd16);
    wait_result(n, to);
    checks++;
    if (to || n != 16 * (LAT + 1) + 1) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d timeout=%0b required %0d", n, to, 16 * (LAT + 1) + 1);
    end
    checks++;
    if (res_bits !== 16'hA5A5 || res_len !== 5'd16) begin
      errors++;
      $display("FAIL basic_result: bits=%h len=%0d required a5a5/16", res_bits, res_len);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: rv=%0b rdy=%0b required 0/1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_wrap;
    int n; bit to; bit ok;
    issue(16'hC003, 4'd14, 5'd4);
    wait_result(n, to);
    ok = (sel_log.size() == 4 * (LAT + 1));
    for (int i = 0; i < sel_log.size() && ok; i++)
      if (sel_log[i] != (14 + i / (LAT + 1)) % 16) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_sel_seq: got %p required 14,15,0,1 each %0d cycles", sel_log, LAT + 1);
    end
    checks++;
    if (to || res_bits !== 16'h000F || res_len !== 5'd4) begin
      errors++;
      $display("FAIL wrap_result: bits=%h len=%0d to=%0b required 000f/4", res_bits, res_len, to);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_count_sat;
    int n; bit to; logic [15:0] w;
    issue(16'h0001, 4'd0, 5'd0);
    wait_result(n, to);
    checks++;
    if (to || res_bits !== 16'h0001 || res_len !== 5'd16) begin
      errors++;
      $display("FAIL count_zero: bits=%h len=%0d required 0001/16", res_bits, res_len);
    end
    @(posedge clk); #1;
    w = 16'($urandom);
    issue(w, 4'd3, 5'd20);
    wait_result(n, to);
    checks++;
    if (to || res_bits !== exp_bits(w, 3, 16) || res_len !== 5'd16 || n != 16 * (LAT + 1) + 1) begin
      errors++;
      $display("FAIL count_20: bits=%h len=%0d cycles=%0d required %h/16/%0d",
               res_bits, res_len, n, exp_bits(w, 3, 16), 16 * (LAT + 1) + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int n; bit to; logic [15:0] w; logic [15:0] e;
    w = 16'($urandom);
    e = exp_bits(w, 9, 5);
    res_ready = 1'b0;
    issue(w, 4'd9, 5'd5);
    wait_result(n, to);
    checks++;
    if (to || n != 5 * (LAT + 1) + 1) begin
      errors++;
      $display("FAIL bp_latency: cycles=%0d to=%0b required %0d", n, to, 5 * (LAT + 1) + 1);
    end
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1; cmd_word = ~w; cmd_start = 4'd0; cmd_count = 5'd1;
      checks++;
      if (res_valid !== 1'b1 || res_bits !== e || res_len !== 5'd5 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rv=%0b bits=%h len=%0d rdy=%0b busy=%0b required 1/%h/5/0/1",
                 i, res_valid, res_bits, res_len, cmd_ready, busy, e);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0 || res_bits !== e) begin
      errors++;
      $display("FAIL bp_accept_cycle: rdy=%0b bits=%h required 0/%h", cmd_ready, res_bits, e);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_after: rdy=%0b rv=%0b busy=%0b required 1/0/0", cmd_ready, res_valid, busy);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    res_ready = 1'b1;
    issue(16'($urandom), 4'd0, 5'd16);
    repeat (3 * (LAT + 1) + 1 - 1) @(posedge clk);
    #1;
    checks++;
    if (mux_sel !== 4'd3 || mux_dis !== 1'b0) begin
      errors++;
      $display("FAIL abort_step3: sel=%0d dis=%0b required 3/0", mux_sel, mux_dis);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mux_dis !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || mux_data !== 16'd0) begin
      errors++;
      $display("FAIL abort_reset: dis=%0b rv=%0b busy=%0b rdy=%0b data=%h required 1/0/0/0/0",
               mux_dis, res_valid, busy, cmd_ready, mux_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: res_valid cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_err;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_before: err=%0b required 0", err);
    end
    force_lo = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%0b required 1", err);
    end
    force_lo = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%0b required 1", err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_rst: err=%0b required 0", err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int n; bit to; int d; logic [15:0] w; logic [3:0] s; logic [4:0] c; logic [15:0] e;
    for (int it = 0; it < 15; it++) begin
      w = 16'($urandom);
      s = 4'($urandom_range(0, 15));
      c = 5'($urandom_range(0, 31));
      e = exp_bits(w, int'(s), eff(int'(c)));
      d = $urandom_range(0, 3);
      res_ready = (d == 0);
      issue(w, s, c);
      wait_result(n, to);
      checks++;
      if (to || n != eff(int'(c)) * (LAT + 1) + 1 || res_bits !== e || res_len !== 5'(eff(int'(c)))) begin
        errors++;
        $display("FAIL random[%0d]: w=%h s=%0d c=%0d bits=%h len=%0d cycles=%0d required %h/%0d/%0d",
                 it, w, s, c, res_bits, res_len, n, e, eff(int'(c)), eff(int'(c)) * (LAT + 1) + 1);
      end
      repeat (d) begin @(posedge clk); #1; end
      res_ready = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL random_end: err=%0b busy=%0b required 0/0", err, busy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_count_sat();
    test_backpressure();
    test_reset_abort();
    test_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
